dmem_wait_responder: RTL and testbench



---
 rtl/dmem_wait_responder.sv | 139 +++++++++++++
 tb/tb_dmem_wait_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_wait_responder.sv
// dmem_wait_responder: configurable-latency data memory that stalls the M stage until each access completes (rev 1.0).
// Optional macro DMEM_ALIGN_CHECK_EN: flags misaligned accesses, suppresses their stores and zeroes their loads.
`default_nettype none

module dmem_wait_responder #(
  parameter int LATENCY    = 2,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] DataAdrM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        AlignErrM
);

  localparam int c_DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  mis_q, mis_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [31:0]           mem_q [c_DEPTH];

  logic                  w_req;
  logic                  w_rd_capture;
  logic [DEPTH_LOG2-1:0] w_rd_idx;
  logic                  w_rd_mis;
  logic                  w_mem_we;
  logic                  w_unused;

  assign w_req = MemReadM | MemWriteM;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    mis_d        = mis_q;
    w_rd_capture = 1'b0;
    w_rd_idx     = idx_q;
    w_rd_mis     = mis_q;
    StallM       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_req) begin
          // Gated by reset so the stall drops the instant reset asserts.
          StallM  = reset;
          idx_d   = DataAdrM[DEPTH_LOG2+1:2];
          wdata_d = WriteDataM;
          we_d    = MemWriteM;
          mis_d   = (DataAdrM[1:0] != 2'b00);
          cnt_d   = 4'(LATENCY - 1);
          if (LATENCY > 1) begin
            state_d = S_WAIT;
          end else begin
            // Single-cycle latency: the latches are not loaded yet, read straight off the bus.
            state_d      = S_DONE;
            w_rd_capture = 1'b1;
            w_rd_idx     = DataAdrM[DEPTH_LOG2+1:2];
            w_rd_mis     = (DataAdrM[1:0] != 2'b00);
          end
        end
      end
      S_WAIT: begin
        StallM = 1'b1;
        cnt_d  = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d      = S_DONE;
          w_rd_capture = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign rdata_d   = w_rd_mis ? 32'h0000_0000 : mem_q[w_rd_idx];
  assign w_mem_we  = reset && (state_q == S_DONE) && we_q && !mis_q;
  assign AlignErrM = (state_q == S_DONE) && mis_q;
  assign w_unused  = ^DataAdrM[31:DEPTH_LOG2+2];
`else
  assign rdata_d   = mem_q[w_rd_idx];
  assign w_mem_we  = reset && (state_q == S_DONE) && we_q;
  assign AlignErrM = 1'b0;
  assign w_unused  = ^{DataAdrM[31:DEPTH_LOG2+2], mis_q, w_rd_mis};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'h0000_0000;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      mis_q   <= mis_d;
      if (w_rd_capture) begin
        rdata_q <= rdata_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign ReadDataM = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_wait_responder.sv
// Directed bench for dmem_wait_responder: one LATENCY=2 instance and one LATENCY=1 instance.
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_wait_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd2, wr2, stall2, aerr2;
  logic [31:0] adr2, wd2, rdata2;
  logic        rd1, wr1, stall1, aerr1;
  logic [31:0] adr1, wd1, rdata1;
  int          nvec = 0;
  int          nerr = 0;
  int          cyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_wait_responder #(.LATENCY(2), .DEPTH_LOG2(6)) dut (
    .clk(clk), .reset(reset), .MemReadM(rd2), .MemWriteM(wr2), .DataAdrM(adr2),
    .WriteDataM(wd2), .ReadDataM(rdata2), .StallM(stall2), .AlignErrM(aerr2)
  );

  dmem_wait_responder #(.LATENCY(1), .DEPTH_LOG2(6)) dut1 (
    .clk(clk), .reset(reset), .MemReadM(rd1), .MemWriteM(wr1), .DataAdrM(adr1),
    .WriteDataM(wd1), .ReadDataM(rdata1), .StallM(stall1), .AlignErrM(aerr1)
  );

  task automatic drive(input bit sel, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel) begin
      rd1 = rd; wr1 = wr; adr1 = a; wd1 = d;
    end else begin
      rd2 = rd; wr2 = wr; adr2 = a; wd2 = d;
    end
  endtask

  // Holds the request until the first non-stalled cycle; returns data/flag seen there.
  task automatic access(input bit sel, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rdata, output int nstall, output logic aerr);
    bit done = 1'b0;
    logic st;
    nstall = 0;
    rdata  = 32'hxxxx_xxxx;
    aerr   = 1'bx;
    drive(sel, rd, wr, a, d);
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      st = sel ? stall1 : stall2;
      if (st) begin
        nstall++;
      end else begin
        done  = 1'b1;
        rdata = sel ? rdata1 : rdata2;
        aerr  = sel ? aerr1 : aerr2;
      end
      @(posedge clk); #1;
    end
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 32'h4, 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    nvec++; if (stall2 !== 1'b0) begin nerr++; $display("FAIL reset_stall2 got=%b exp=0", stall2); end
    nvec++; if (stall1 !== 1'b0) begin nerr++; $display("FAIL reset_stall1 got=%b exp=0", stall1); end
    nvec++; if (rdata2 !== 32'h0) begin nerr++; $display("FAIL reset_rdata2 got=%h exp=0", rdata2); end
    nvec++; if (rdata1 !== 32'h0) begin nerr++; $display("FAIL reset_rdata1 got=%h exp=0", rdata1); end
    nvec++; if (aerr2 !== 1'b0) begin nerr++; $display("FAIL reset_aerr2 got=%b exp=0", aerr2); end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_latency2;
    logic [31:0] rd; int ns; logic ae;
    access(1'b0, 1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF, rd, ns, ae);
    nvec++; if (ns !== 2) begin nerr++; $display("FAIL lat2_store_stall got=%0d exp=2", ns); end
    access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, rd, ns, ae);
    nvec++; if (ns !== 2) begin nerr++; $display("FAIL lat2_load_stall got=%0d exp=2", ns); end
    nvec++; if (rd !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL lat2_load_data got=%h exp=deadbeef", rd); end
    nvec++; if (ae !== 1'b0) begin nerr++; $display("FAIL lat2_aerr got=%b exp=0", ae); end
    @(negedge clk);
    nvec++; if (rdata2 !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL lat2_hold got=%h exp=deadbeef", rdata2); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; int ns; logic ae; int c0;
    c0 = cyc;
    access(1'b1, 1'b0, 1'b1, 32'h4, 32'h11, rd, ns, ae);
    nvec++; if (ns !== 1) begin nerr++; $display("FAIL b2b_store_stall got=%0d exp=1", ns); end
    access(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, rd, ns, ae);
    nvec++; if (ns !== 1) begin nerr++; $display("FAIL b2b_load_stall got=%0d exp=1", ns); end
    nvec++; if (rd !== 32'h11) begin nerr++; $display("FAIL b2b_load_data got=%h exp=11", rd); end
    nvec++; if (cyc - c0 !== 4) begin nerr++; $display("FAIL b2b_cycles got=%0d exp=4", cyc - c0); end
  endtask

  task automatic test_bus_change;
    logic [31:0] rd; int ns; logic ae;
    access(1'b0, 1'b0, 1'b1, 32'h40, 32'h0000_4040, rd, ns, ae);
    drive(1'b0, 1'b0, 1'b1, 32'h8, 32'h0BAD_F00D);
    @(negedge clk);
    nvec++; if (stall2 !== 1'b1) begin nerr++; $display("FAIL bus_accept_stall got=%b exp=1", stall2); end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 32'h40, 32'h0000_FFFF);
    @(negedge clk);
    nvec++; if (stall2 !== 1'b1) begin nerr++; $display("FAIL bus_wait_stall got=%b exp=1", stall2); end
    @(posedge clk); #1;
    @(negedge clk);
    nvec++; if (stall2 !== 1'b0) begin nerr++; $display("FAIL bus_done_stall got=%b exp=0", stall2); end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    access(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, rd, ns, ae);
    nvec++; if (rd !== 32'h0BAD_F00D) begin nerr++; $display("FAIL bus_orig_addr got=%h exp=0badf00d", rd); end
    access(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, rd, ns, ae);
    nvec++; if (rd !== 32'h0000_4040) begin nerr++; $display("FAIL bus_other_addr got=%h exp=00004040", rd); end
  endtask

  task automatic test_reset_mid_wait;
    logic [31:0] rd; int ns; logic ae;
    access(1'b0, 1'b0, 1'b1, 32'hC, 32'h0000_1234, rd, ns, ae);
    drive(1'b0, 1'b0, 1'b1, 32'hC, 32'h5);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    nvec++; if (stall2 !== 1'b0) begin nerr++; $display("FAIL rstwait_stall got=%b exp=0", stall2); end
    nvec++; if (rdata2 !== 32'h0) begin nerr++; $display("FAIL rstwait_rdata got=%h exp=0", rdata2); end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    access(1'b0, 1'b1, 1'b0, 32'hC, 32'h0, rd, ns, ae);
    nvec++; if (ns !== 2) begin nerr++; $display("FAIL rstwait_reload_stall got=%0d exp=2", ns); end
    nvec++; if (rd !== 32'h0000_1234) begin nerr++; $display("FAIL rstwait_mem got=%h exp=00001234", rd); end
  endtask

  task automatic test_wrap_simultaneous;
    logic [31:0] rd; int ns; logic ae;
    access(1'b0, 1'b0, 1'b1, 32'h100, 32'hA5, rd, ns, ae);
    access(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, rd, ns, ae);
    nvec++; if (rd !== 32'hA5) begin nerr++; $display("FAIL wrap_load got=%h exp=a5", rd); end
    access(1'b0, 1'b1, 1'b1, 32'h0, 32'h7, rd, ns, ae);
    nvec++; if (ns !== 2) begin nerr++; $display("FAIL both_stall got=%0d exp=2", ns); end
    nvec++; if (rd !== 32'hA5) begin nerr++; $display("FAIL both_old_data got=%h exp=a5", rd); end
    access(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, rd, ns, ae);
    nvec++; if (rd !== 32'h7) begin nerr++; $display("FAIL both_new_data got=%h exp=7", rd); end
  endtask

  task automatic test_align;
    logic [31:0] rd; int ns; logic ae;
    logic        exp_ae;
    logic [31:0] exp_w8, exp_mis_rd;
`ifdef DMEM_ALIGN_CHECK_EN
    exp_ae     = 1'b1;
    exp_w8     = 32'h0000_0808;
    exp_mis_rd = 32'h0;
`else
    exp_ae     = 1'b0;
    exp_w8     = 32'h9;
    exp_mis_rd = 32'h9;
`endif
    access(1'b0, 1'b0, 1'b1, 32'h20, 32'h0000_0808, rd, ns, ae);
    access(1'b0, 1'b0, 1'b1, 32'h22, 32'h9, rd, ns, ae);
    nvec++; if (ae !== exp_ae) begin nerr++; $display("FAIL align_store_flag got=%b exp=%b", ae, exp_ae); end
    nvec++; if (ns !== 2) begin nerr++; $display("FAIL align_store_stall got=%0d exp=2", ns); end
    access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, rd, ns, ae);
    nvec++; if (rd !== exp_w8) begin nerr++; $display("FAIL align_word8 got=%h exp=%h", rd, exp_w8); end
    nvec++; if (ae !== 1'b0) begin nerr++; $display("FAIL align_aligned_flag got=%b exp=0", ae); end
    access(1'b0, 1'b1, 1'b0, 32'h21, 32'h0, rd, ns, ae);
    nvec++; if (rd !== exp_mis_rd) begin nerr++; $display("FAIL align_load_data got=%h exp=%h", rd, exp_mis_rd); end
    nvec++; if (ae !== exp_ae) begin nerr++; $display("FAIL align_load_flag got=%b exp=%b", ae, exp_ae); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency2();
    test_back_to_back();
    test_bus_change();
    test_reset_mid_wait();
    test_wrap_simultaneous();
    test_align();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
